// File: rtl/pkt_fifo_commit_pkg.sv
// Shared defaults and write-side state encodings for the packet FIFO.
package pkt_fifo_commit_pkg;
  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 9;

  // Write side either passes words into storage or discards until packet end.
  localparam logic [0:0] WR_PASS    = 1'b0;
  localparam logic [0:0] WR_DISCARD = 1'b1;
endpackage

// File: rtl/pkt_fifo_commit_if.sv
// Write/read bus of the packet FIFO; master drives writes and pops, slave is the FIFO.
interface pkt_fifo_commit_if import pkt_fifo_commit_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
);
  logic [DWIDTH-1:0] wr_data;
  logic              wr_last;
  logic              wr_ena;
  logic              wr_drop;
  logic              full;
  logic              wr_ovf;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_last;
  logic              rd_ena;
  logic              empty;
  logic [AWIDTH:0]   pkt_cnt;

  modport master (
    output wr_data, wr_last, wr_ena, wr_drop, rd_ena,
    input  full, wr_ovf, rd_data, rd_last, empty, pkt_cnt
  );

  modport slave (
    input  wr_data, wr_last, wr_ena, wr_drop, rd_ena,
    output full, wr_ovf, rd_data, rd_last, empty, pkt_cnt
  );
endinterface

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port that holds when re=0.
module ram_sdp #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pkt_fifo_commit.sv
// Packet FIFO with commit-on-last: words become readable only once their packet's last word lands.
// Empty falls two edges after the committing write; writes are not stalled, overflowing packets are dropped whole.
module pkt_fifo_commit import pkt_fifo_commit_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input logic              clk,
  input logic              rst,
  pkt_fifo_commit_if.slave bus
);
  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH:0]   wptr, cptr, rptr, pkt_cnt;
  logic [0:0]        wr_state;
  logic              ovf_pulse, full, wr_accept, wr_commit;
  logic              fetch, fvld, out_load, out_vld, out_last, rd_pop, pkt_dec;
  logic [DWIDTH-1:0] out_dat;
  logic [DWIDTH:0]   ram_q;

  // Occupancy is measured against the RAM read pointer, so uncommitted words count.
  assign full      = (wptr - rptr) == DEPTH;
  assign wr_accept = bus.wr_ena && !bus.wr_drop && !full && (wr_state == WR_PASS);
  assign wr_commit = wr_accept && bus.wr_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      cptr      <= '0;
      wr_state  <= WR_PASS;
      ovf_pulse <= 1'b0;
    end else begin
      ovf_pulse <= 1'b0;
      if (bus.wr_drop) begin
        wptr     <= cptr;
        wr_state <= WR_PASS;
      end else if (bus.wr_ena) begin
        if (wr_accept) begin
          wptr <= wptr + 1'b1;
          if (bus.wr_last) cptr <= wptr + 1'b1;
        end else if (bus.wr_last) begin
          // End of an overflowed packet: throw away what was stored of it.
          wptr      <= cptr;
          wr_state  <= WR_PASS;
          ovf_pulse <= 1'b1;
        end else begin
          wr_state <= WR_DISCARD;
        end
      end
    end
  end

  // Two-stage read pipe: RAM output register (fvld) feeding the FWFT output register.
  assign rd_pop   = bus.rd_ena && out_vld;
  assign out_load = fvld && (!out_vld || bus.rd_ena);
  assign fetch    = (rptr != cptr) && (!fvld || out_load);
  assign pkt_dec  = rd_pop && out_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr     <= '0;
      fvld     <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_dat  <= '0;
    end else begin
      if (fetch) rptr <= rptr + 1'b1;
      if (fetch)         fvld <= 1'b1;
      else if (out_load) fvld <= 1'b0;
      if (out_load) begin
        out_vld  <= 1'b1;
        out_dat  <= ram_q[DWIDTH-1:0];
        out_last <= ram_q[DWIDTH];
      end else if (rd_pop) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr_commit, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  ram_sdp #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wptr[AWIDTH-1:0]),
    .wdata ({bus.wr_last, bus.wr_data}),
    .re    (fetch),
    .raddr (rptr[AWIDTH-1:0]),
    .rdata (ram_q)
  );

  assign bus.full    = full;
  assign bus.wr_ovf  = ovf_pulse;
  assign bus.rd_data = out_dat;
  assign bus.rd_last = out_last;
  assign bus.empty   = !out_vld;
  assign bus.pkt_cnt = pkt_cnt;
endmodule

// File: tb/tb_pkt_fifo_commit.sv
// Directed bench for pkt_fifo_commit at DWIDTH=8, AWIDTH=4 (16-word storage).
module tb_pkt_fifo_commit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pkt_fifo_commit_if #(.DWIDTH(8), .AWIDTH(4)) bus ();

  pkt_fifo_commit #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_ena  = 1'b0;
    bus.wr_last = 1'b0;
    bus.wr_drop = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_ena  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    bus.wr_ena  = 1'b1;
    bus.wr_data = d;
    bus.wr_last = last;
    tick();
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] d, input logic last);
    chk({tag, "_empty"}, bus.empty, 1'b0);
    chk({tag, "_data"}, bus.rd_data, d);
    chk({tag, "_last"}, bus.rd_last, last);
    bus.rd_ena = 1'b1;
    tick();
    bus.rd_ena = 1'b0;
  endtask

  initial begin
    int exp_i;
    int bubbles;
    int full_seen;

    idle();
    #3;
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("rst_wr_ovf", bus.wr_ovf, 1'b0);
    chk("rst_rd_last", bus.rd_last, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 4-word packet, empty falls on the second edge after the last write
    for (int i = 0; i < 4; i++) wr(8'(8'h11 + i), i == 3);
    idle();
    chk("p4_empty_e0", bus.empty, 1'b1);
    chk("p4_cnt", bus.pkt_cnt, 1);
    tick();
    chk("p4_empty_e1", bus.empty, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("p4_cnt_rd", bus.pkt_cnt, 1);
      rd_expect("p4", 8'(8'h11 + i), i == 3);
    end
    chk("p4_empty_end", bus.empty, 1'b1);
    chk("p4_cnt_end", bus.pkt_cnt, 0);

    // Fill all 16 slots, then a 2-word packet that must overflow
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i), i == 15);
    chk("fill_full", bus.full, 1'b1);
    chk("fill_ovf0", bus.wr_ovf, 1'b0);
    wr(8'hE0, 1'b0);
    chk("ovf_pulse_early", bus.wr_ovf, 1'b0);
    wr(8'hE1, 1'b1);
    idle();
    chk("ovf_pulse", bus.wr_ovf, 1'b1);
    tick();
    chk("ovf_pulse_once", bus.wr_ovf, 1'b0);
    chk("ovf_cnt", bus.pkt_cnt, 1);
    for (int i = 0; i < 16; i++) rd_expect("fill", 8'(8'h20 + i), i == 15);
    tick();
    tick();
    chk("ovf_nothing_left", bus.empty, 1'b1);
    chk("ovf_cnt_end", bus.pkt_cnt, 0);

    // Partial packet aborted with wr_drop, then a clean 2-word packet
    wr(8'h30, 1'b0);
    wr(8'h31, 1'b0);
    wr(8'h32, 1'b0);
    idle();
    bus.wr_drop = 1'b1;
    tick();
    bus.wr_drop = 1'b0;
    chk("drop_cnt", bus.pkt_cnt, 0);
    wr(8'hA0, 1'b0);
    wr(8'hA1, 1'b1);
    idle();
    chk("drop_cnt_peak", bus.pkt_cnt, 1);
    tick();
    tick();
    rd_expect("drop_a0", 8'hA0, 1'b0);
    rd_expect("drop_a1", 8'hA1, 1'b1);
    chk("drop_empty", bus.empty, 1'b1);
    chk("drop_cnt_end", bus.pkt_cnt, 0);

    // wr_drop overrides a same-cycle write of the last word
    wr(8'h40, 1'b0);
    wr(8'h41, 1'b0);
    bus.wr_drop = 1'b1;
    wr(8'h42, 1'b1);
    idle();
    chk("dropena_ovf", bus.wr_ovf, 1'b0);
    chk("dropena_cnt", bus.pkt_cnt, 0);
    tick();
    chk("dropena_ovf2", bus.wr_ovf, 1'b0);
    tick();
    chk("dropena_empty", bus.empty, 1'b1);
    wr(8'h50, 1'b1);
    idle();
    tick();
    tick();
    rd_expect("after_dropena", 8'h50, 1'b1);
    chk("after_dropena_empty", bus.empty, 1'b1);

    // Streaming: 3 packets of 8 words written back-to-back with rd_ena held
    exp_i = 0;
    bubbles = 0;
    full_seen = 0;
    for (int c = 0; c < 80 && exp_i < 24; c++) begin
      if (c < 24) begin
        bus.wr_ena  = 1'b1;
        bus.wr_data = 8'(8'h60 + c);
        bus.wr_last = (c % 8) == 7;
      end else begin
        bus.wr_ena  = 1'b0;
        bus.wr_last = 1'b0;
      end
      bus.rd_ena = 1'b1;
      tick();
      if (bus.full) full_seen++;
      if (!bus.empty) begin
        chk("stream_data", bus.rd_data, 32'(8'h60 + exp_i));
        chk("stream_last", bus.rd_last, (exp_i % 8) == 7);
        exp_i++;
      end else if (exp_i > 0) begin
        bubbles++;
      end
    end
    tick();
    idle();
    chk("stream_words", exp_i, 24);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_full_seen", full_seen, 0);
    chk("stream_empty", bus.empty, 1'b1);
    chk("stream_cnt", bus.pkt_cnt, 0);

    // Asynchronous reset with two packets stored and a third in flight
    wr(8'h70, 1'b0);
    wr(8'h71, 1'b1);
    wr(8'h72, 1'b0);
    wr(8'h73, 1'b1);
    wr(8'h74, 1'b0);
    chk("prerst_cnt", bus.pkt_cnt, 2);
    chk("prerst_empty", bus.empty, 1'b0);
    #2;
    rst = 1'b0;
    idle();
    #1;
    chk("arst_empty", bus.empty, 1'b1);
    chk("arst_cnt", bus.pkt_cnt, 0);
    chk("arst_full", bus.full, 1'b0);
    chk("arst_rd_last", bus.rd_last, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("postrst_empty", bus.empty, 1'b1);
    wr(8'h80, 1'b0);
    wr(8'h81, 1'b1);
    idle();
    chk("postrst_cnt", bus.pkt_cnt, 1);
    tick();
    tick();
    rd_expect("postrst_80", 8'h80, 1'b0);
    rd_expect("postrst_81", 8'h81, 1'b1);
    chk("postrst_empty_end", bus.empty, 1'b1);
    chk("postrst_cnt_end", bus.pkt_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
